// File: rtl/xrst_evidence_intake_mc.sv
`default_nettype none
// ============================================================================
// Module   : xrst_evidence_intake_mc
// Brief    : Round-robin intake of XRAS evidence packets, parse/validate, FIFO.
// Revision : 1.0
// ============================================================================
module xrst_evidence_intake_mc #(
  parameter int          NUM_CH  = 4,
  parameter int          DEPTH   = 8,
  parameter logic [31:0] MAX_AGE = 32'd1000,
  parameter logic [15:0] MAGIC   = 16'hCAFE,
  localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*4096-1:0]   evidence_packet,
  input  logic [NUM_CH-1:0]        packet_valid,
  output logic [NUM_CH-1:0]        packet_ready,
  input  logic [31:0]              now_time,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [31:0]              sla_id,
  output logic [31:0]              timestamp,
  output logic [31:0]              reliability_score,
  output logic [31:0]              penalty_amount,
  output logic [31:0]              credit_amount,
  output logic [15:0]              boundary_id,
  output logic [255:0]             causal_chain,
  output logic [255:0]             compliance_proof,
  output logic [7:0]               evidence_status,
  output logic [CH_W-1:0]          ev_channel,
  output logic [ADDR_W:0]          fifo_count,
  output logic [15:0]              invalid_count,
  output logic [15:0]              expired_count
);

  localparam int c_FIELD_W = 688;
  localparam int c_REC_W   = c_FIELD_W + 8 + CH_W;

  logic [CH_W-1:0]    r_rr_ptr;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic [15:0]        r_invalid_count;
  logic [15:0]        r_expired_count;
  logic [c_REC_W-1:0] r_mem [DEPTH];

  logic               w_found;
  logic [CH_W-1:0]    w_grant;
  logic [CH_W-1:0]    w_cand;
  logic               w_full;
  logic               w_nonempty;
  logic               w_push;
  logic               w_pop;
  logic [703:0]       w_pkt;
  logic [31:0]        w_age;
  logic [7:0]         w_status;
  logic [c_REC_W-1:0] w_rec;
  logic [c_REC_W-1:0] w_head;
  logic               w_unused_pkt_bits;

  // Rotating priority: first valid channel at or after r_rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
      if (!w_found && packet_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  assign w_full     = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_push     = rst_n && w_found && !w_full;
  assign w_pop      = w_nonempty && ev_ready;

  assign w_pkt = evidence_packet[int'(w_grant)*4096 +: 704];
  assign w_age = now_time - w_pkt[63:32];
  assign w_unused_pkt_bits = ^evidence_packet;

  // Signature failure dominates; modulo age makes future timestamps expire.
  always_comb begin
    if (w_pkt[703:688] != MAGIC)
      w_status = 8'd1;
    else if (w_age > MAX_AGE)
      w_status = 8'd2;
    else
      w_status = 8'd0;
  end

  assign w_rec  = {w_grant, w_status, w_pkt[c_FIELD_W-1:0]};
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    packet_ready = '0;
    if (w_push)
      packet_ready = NUM_CH'(1) << w_grant;
  end

  always_comb begin
    ev_valid          = w_nonempty;
    ev_channel        = '0;
    evidence_status   = 8'd1;
    compliance_proof  = '0;
    causal_chain      = '0;
    boundary_id       = '0;
    credit_amount     = '0;
    penalty_amount    = '0;
    reliability_score = '0;
    timestamp         = '0;
    sla_id            = '0;
    if (w_nonempty)
      {ev_channel, evidence_status, compliance_proof, causal_chain, boundary_id,
       credit_amount, penalty_amount, reliability_score, timestamp, sla_id} = w_head;
  end

  assign fifo_count    = r_count;
  assign invalid_count = r_invalid_count;
  assign expired_count = r_expired_count;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_invalid_count <= '0;
      r_expired_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= CH_W'((int'(w_grant) + 1) % NUM_CH);
        if (w_status == 8'd1 && r_invalid_count != 16'hFFFF)
          r_invalid_count <= r_invalid_count + 16'd1;
        if (w_status == 8'd2 && r_expired_count != 16'hFFFF)
          r_expired_count <= r_expired_count + 16'd1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xrst_evidence_intake_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_xrst_evidence_intake_mc
// Brief    : Directed self-checking bench for xrst_evidence_intake_mc.
// Revision : 1.0
// ============================================================================
module tb_xrst_evidence_intake_mc;

  logic              clk;
  logic              rst_n;
  logic [4*4096-1:0] evidence_packet;
  logic [3:0]        packet_valid;
  logic [3:0]        packet_ready;
  logic [31:0]       now_time;
  logic              ev_valid;
  logic              ev_ready;
  logic [31:0]       sla_id, timestamp, reliability_score, penalty_amount, credit_amount;
  logic [15:0]       boundary_id;
  logic [255:0]      causal_chain, compliance_proof;
  logic [7:0]        evidence_status;
  logic [1:0]        ev_channel;
  logic [3:0]        fifo_count;
  logic [15:0]       invalid_count, expired_count;

  int n_pass  = 0;
  int n_total = 0;

  xrst_evidence_intake_mc #(
    .NUM_CH(4), .DEPTH(8), .MAX_AGE(32'd1000), .MAGIC(16'hCAFE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .evidence_packet(evidence_packet), .packet_valid(packet_valid),
    .packet_ready(packet_ready), .now_time(now_time),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .sla_id(sla_id), .timestamp(timestamp), .reliability_score(reliability_score),
    .penalty_amount(penalty_amount), .credit_amount(credit_amount),
    .boundary_id(boundary_id), .causal_chain(causal_chain),
    .compliance_proof(compliance_proof), .evidence_status(evidence_status),
    .ev_channel(ev_channel), .fifo_count(fifo_count),
    .invalid_count(invalid_count), .expired_count(expired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4095:0] mk(input logic [31:0] sla, input logic [31:0] ts,
                                       input logic [15:0] sig);
    logic [4095:0] p;
    p = '1;
    p[31:0]    = sla;
    p[63:32]   = ts;
    p[95:64]   = sla ^ 32'hA5A5A5A5;
    p[127:96]  = sla + 32'd1;
    p[159:128] = sla + 32'd2;
    p[175:160] = sla[15:0] ^ 16'h1234;
    p[431:176] = {8{sla}};
    p[687:432] = {8{~sla}};
    p[703:688] = sig;
    return p;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_one(input int ch, input logic [4095:0] p);
    evidence_packet[ch*4096 +: 4096] = p;
    packet_valid = 4'(1 << ch);
    #1;
    check("push_ready", packet_ready, 256'(1 << ch));
    @(posedge clk);
    #1;
    packet_valid = 4'b0;
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(posedge clk);
    #1;
    ev_ready = 1'b0;
  endtask

  initial begin
    int  sent;
    int  expv;
    logic acc;

    rst_n           = 1'b0;
    packet_valid    = 4'hF;
    ev_ready        = 1'b0;
    now_time        = 32'd0;
    evidence_packet = '0;
    #12;
    check("rst_ready", packet_ready, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_status", evidence_status, 1);
    check("rst_count", fifo_count, 0);
    check("rst_inv", invalid_count, 0);
    check("rst_exp", expired_count, 0);
    packet_valid = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single valid packet on channel 0
    now_time = 32'd150;
    push_one(0, mk(32'h11111111, 32'd100, 16'hCAFE));
    check("single_valid", ev_valid, 1);
    check("single_status", evidence_status, 0);
    check("single_chan", ev_channel, 0);
    check("single_sla", sla_id, 32'h11111111);
    check("single_ts", timestamp, 32'd100);
    check("single_rel", reliability_score, 32'hB4B4B4B4);
    check("single_pen", penalty_amount, 32'h11111112);
    check("single_cred", credit_amount, 32'h11111113);
    check("single_bnd", boundary_id, 16'h0325);
    check("single_causal", causal_chain, {8{32'h11111111}});
    check("single_proof", compliance_proof, {8{32'hEEEEEEEE}});
    check("single_count", fifo_count, 1);
    pop_one();
    check("empty_valid", ev_valid, 0);
    check("empty_status", evidence_status, 1);
    check("empty_sla", sla_id, 0);

    // Status classification and counters
    push_one(2, mk(32'd22, 32'd100, 16'hBEEF));
    check("bad_sig_status", evidence_status, 1);
    check("bad_sig_chan", ev_channel, 2);
    check("bad_sig_inv", invalid_count, 1);
    pop_one();
    now_time = 32'd1200;
    push_one(1, mk(32'd33, 32'd100, 16'hCAFE));
    check("old_status", evidence_status, 2);
    check("old_exp", expired_count, 1);
    pop_one();
    now_time = 32'd100;
    push_one(3, mk(32'd44, 32'd200, 16'hCAFE));
    check("future_status", evidence_status, 2);
    check("future_exp", expired_count, 2);
    pop_one();
    now_time = 32'd1000;
    push_one(0, mk(32'd55, 32'd0, 16'hCAFE));
    check("age_eq_max_status", evidence_status, 0);
    pop_one();
    now_time = 32'd1001;
    push_one(0, mk(32'd56, 32'd0, 16'hCAFE));
    check("age_over_max_status", evidence_status, 2);
    check("age_over_max_exp", expired_count, 3);
    check("inv_unchanged", invalid_count, 1);
    pop_one();

    // Round-robin with all channels requesting and consumer always ready
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    now_time = 32'd0;
    for (int c = 0; c < 4; c++)
      evidence_packet[c*4096 +: 4096] = mk(32'(c), 32'd0, 16'hCAFE);
    packet_valid = 4'hF;
    ev_ready     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ready", packet_ready, 256'(1 << (k % 4)));
      @(posedge clk);
      #1;
      check("rr_chan", ev_channel, k % 4);
      check("rr_sla", sla_id, k % 4);
      check("rr_count", fifo_count, 1);
    end
    packet_valid = 4'b0;
    @(posedge clk);
    #1;
    check("rr_drained", ev_valid, 0);
    ev_ready = 1'b0;

    // Fill to full on channel 1 and drain with backpressure release
    for (int i = 0; i < 8; i++) begin
      evidence_packet[4096 +: 4096] = mk(32'(100 + i), 32'd0, 16'hCAFE);
      packet_valid = 4'b0010;
      #1;
      check("fill_ready", packet_ready, 4'b0010);
      @(posedge clk);
      #1;
    end
    check("full_count", fifo_count, 8);
    sent = 8;
    expv = 100;
    ev_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (sent < 10) begin
        evidence_packet[4096 +: 4096] = mk(32'(100 + sent), 32'd0, 16'hCAFE);
        packet_valid = 4'b0010;
      end else begin
        packet_valid = 4'b0;
      end
      #1;
      check("drain_valid", ev_valid, 1);
      check("drain_sla", sla_id, 32'(expv));
      if (c == 0)
        check("full_ready_low", packet_ready, 0);
      acc = packet_ready[1];
      @(posedge clk);
      #1;
      expv++;
      if (acc) sent++;
    end
    check("drain_sent", sent, 10);
    check("drain_empty", ev_valid, 0);
    check("drain_count", fifo_count, 0);
    ev_ready     = 1'b0;
    packet_valid = 4'b0;

    // Asynchronous reset with records buffered
    for (int i = 0; i < 5; i++) begin
      evidence_packet[2*4096 +: 4096] = mk(32'(200 + i), 32'd0, (i == 0) ? 16'hBEEF : 16'hCAFE);
      packet_valid = 4'b0100;
      @(posedge clk);
      #1;
    end
    check("pre_rst_count", fifo_count, 5);
    check("pre_rst_inv", invalid_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", ev_valid, 0);
    check("arst_count", fifo_count, 0);
    check("arst_status", evidence_status, 1);
    check("arst_inv", invalid_count, 0);
    check("arst_exp", expired_count, 0);
    check("arst_sla", sla_id, 0);
    check("arst_ready", packet_ready, 0);
    packet_valid = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", packet_ready, 4'b0001);
    @(posedge clk);
    #1;
    check("post_rst_chan", ev_channel, 0);
    check("post_rst_count", fifo_count, 1);
    packet_valid = 4'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
